rv32_x_fetch_buf: RTL and testbench

Instruction fetch front-end for the rv32i_x core. It sits between the core's decode stage and the ICCM read port of `ccm`. It generates sequential fetch addresses, issues single-cycle ICCM reads, and buffers returned instructions with their PCs in a small FIFO. It hands instructions to decode over a valid/ready handshake and flushes cleanly on a redirect (branch, jump or trap).

---
 rtl/rv32_x_fetch_buf.sv | 150 +++++++++++++++
 tb/tb_rv32_x_fetch_buf.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/rv32_x_fetch_buf.sv
// Instruction fetch buffer for rv32i_x: sequential ICCM fetch, {pc, inst} FIFO, redirect flush.
// Define FETCH_BYPASS_EN to forward a response straight to decode when the FIFO is empty.
module rv32_x_fetch_buf #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        iccm_rd_en,
   output logic [31:0] iccm_rd_addr,
   input  logic [31:0] iccm_rd_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        inst_ready
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW:0] DEPTH_OCC = DEPTH[CW:0];

   typedef enum logic [1:0] {
      S_BOOT,
      S_FETCH,
      S_FULL
   } state_t;

   state_t        state;
   state_t        state_next;

   logic [31:0]   fetch_pc;
   logic [31:0]   pc_mem   [DEPTH];
   logic [31:0]   inst_mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] count_next;
   logic [CW:0]   occ_next;
   logic          inflight;
   logic [31:0]   inflight_pc;
   logic          kill;

   logic          head_valid;
   logic          credit_ok;
   logic          resp_live;
   logic          bypass;
   logic          issue;
   logic          push;
   logic          pop;

   // A redirect discards any response arriving in the same cycle and any pop decode attempts.
   always_comb begin
      head_valid = (count != '0);
      credit_ok  = ({1'b0, count} + (CW+1)'(inflight)) < DEPTH_OCC;
      resp_live  = inflight & ~kill & ~redirect_valid;
`ifdef FETCH_BYPASS_EN
      bypass     = resp_live & ~head_valid & inst_ready;
`else
      bypass     = 1'b0;
`endif
      issue      = (state == S_FETCH) & credit_ok & ~redirect_valid;
      push       = resp_live & ~bypass;
      pop        = head_valid & inst_ready & ~redirect_valid;
      if (redirect_valid)
         count_next = '0;
      else
         count_next = count + CW'(push) - CW'(pop);
      occ_next   = {1'b0, count_next} + (CW+1)'(issue);
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= S_BOOT;
      else
         state <= state_next;
   end

   // FULL tracks whether next cycle's buffered plus outstanding fetches use every slot.
   always_comb begin
      state_next = state;
      case (state)
         S_BOOT:  state_next = S_FETCH;
         default: begin
            if (redirect_valid)
               state_next = S_FETCH;
            else if (occ_next == DEPTH_OCC)
               state_next = S_FULL;
            else
               state_next = S_FETCH;
         end
      endcase
   end

   always_comb begin
      iccm_rd_en   = issue;
      iccm_rd_addr = fetch_pc;
      inst_valid   = head_valid | bypass;
      inst         = '0;
      inst_pc      = '0;
      if (head_valid) begin
         inst    = inst_mem[rd_ptr];
         inst_pc = pc_mem[rd_ptr];
      end else if (bypass) begin
         inst    = iccm_rd_data;
         inst_pc = inflight_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc    <= RESET_PC;
         count       <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         inflight    <= 1'b0;
         inflight_pc <= '0;
         kill        <= 1'b0;
      end else begin
         inflight <= issue;
         count    <= count_next;
         if (issue)
            inflight_pc <= fetch_pc;
         if (redirect_valid) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            kill     <= issue;
         end else begin
            if (issue)
               fetch_pc <= fetch_pc + 32'd4;
            if (push)
               wr_ptr <= wr_ptr + PW'(1);
            if (pop)
               rd_ptr <= rd_ptr + PW'(1);
            if (inflight & kill)
               kill <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && push) begin
         pc_mem[wr_ptr]   <= inflight_pc;
         inst_mem[wr_ptr] <= iccm_rd_data;
      end
   end

endmodule

// File: tb/tb_rv32_x_fetch_buf.sv
// Directed and scoreboard bench for rv32_x_fetch_buf with a one-cycle-latency ICCM model.
// Expected issue-to-valid latency follows FETCH_BYPASS_EN.
module tb_rv32_x_fetch_buf;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0100;
`ifdef FETCH_BYPASS_EN
   localparam int          LAT      = 1;
`else
   localparam int          LAT      = 2;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        iccm_rd_en;
   logic [31:0] iccm_rd_addr;
   logic [31:0] iccm_rd_data = '0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_ready = 1'b0;

   int          checks = 0;
   int          errors = 0;
   int          delivered;
   logic        rdy;
   logic        rv;
   logic [31:0] rpc;
   logic [31:0] expPc;
   logic [31:0] holdPc;
   logic        holdValid;

   rv32_x_fetch_buf #(
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .iccm_rd_en     (iccm_rd_en),
      .iccm_rd_addr   (iccm_rd_addr),
      .iccm_rd_data   (iccm_rd_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .inst_ready     (inst_ready)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] iccmWord(input logic [31:0] a);
      return (a ^ 32'h5A5A_C3C3) + {a[15:0], a[31:16]};
   endfunction

   // ICCM model: data for the strobed address appears the following cycle.
   always @(posedge clk) begin
      if (iccm_rd_en)
         iccm_rd_data <= iccmWord(iccm_rd_addr);
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic rdyIn, input logic rvIn, input logic [31:0] rpcIn);
      @(negedge clk);
      rst            = r;
      inst_ready     = rdyIn;
      redirect_valid = rvIn;
      redirect_pc    = rpcIn;
      #1;
   endtask

   task automatic resetDut(input logic bootReady);
      applyStimulus(1'b1, 1'b0, 1'b0, '0);
      applyStimulus(1'b1, 1'b0, 1'b0, '0);
      checkOutput("rst_rd_en", 32'(iccm_rd_en), 32'd0);
      checkOutput("rst_rd_addr", iccm_rd_addr, RESET_PC);
      checkOutput("rst_valid", 32'(inst_valid), 32'd0);
      checkOutput("rst_inst", inst, 32'd0);
      checkOutput("rst_inst_pc", inst_pc, 32'd0);
      applyStimulus(1'b0, bootReady, 1'b0, '0);
      checkOutput("boot_rd_en", 32'(iccm_rd_en), 32'd0);
   endtask

   // Cycle 1 is the first read of base; ready held high throughout.
   task automatic checkRun(input logic [31:0] base, input int n);
      logic [31:0] pc;
      for (int i = 1; i <= n; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, '0);
         checkOutput("run_rd_en", 32'(iccm_rd_en), 32'd1);
         checkOutput("run_rd_addr", iccm_rd_addr, base + 32'(4 * (i - 1)));
         if (i > LAT) begin
            pc = base + 32'(4 * (i - 1 - LAT));
            checkOutput("run_valid", 32'(inst_valid), 32'd1);
            checkOutput("run_inst_pc", inst_pc, pc);
            checkOutput("run_inst", inst, iccmWord(pc));
         end else begin
            checkOutput("run_valid_early", 32'(inst_valid), 32'd0);
         end
      end
   endtask

   initial begin
      $display("[TB] reset release and sequential fetch");
      resetDut(1'b1);
      checkRun(RESET_PC, 6);

      $display("[TB] backpressure fills the buffer");
      resetDut(1'b0);
      for (int i = 1; i <= 4; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, '0);
         checkOutput("fill_rd_en", 32'(iccm_rd_en), 32'd1);
         checkOutput("fill_rd_addr", iccm_rd_addr, RESET_PC + 32'(4 * (i - 1)));
      end
      for (int i = 5; i <= 8; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, '0);
         checkOutput("full_rd_en", 32'(iccm_rd_en), 32'd0);
      end
      checkOutput("full_valid", 32'(inst_valid), 32'd1);
      checkOutput("full_head_pc", inst_pc, RESET_PC);
      checkOutput("full_head_inst", inst, iccmWord(RESET_PC));
      for (int k = 0; k <= 4; k++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, '0);
         checkOutput("drain_valid", 32'(inst_valid), 32'd1);
         checkOutput("drain_pc", inst_pc, RESET_PC + 32'(4 * k));
         checkOutput("drain_inst", inst, iccmWord(RESET_PC + 32'(4 * k)));
         if (k == 0)
            checkOutput("drain_no_issue", 32'(iccm_rd_en), 32'd0);
         if (k == 1) begin
            checkOutput("resume_rd_en", 32'(iccm_rd_en), 32'd1);
            checkOutput("resume_rd_addr", iccm_rd_addr, 32'h0000_0110);
         end
      end

      $display("[TB] redirect with read in flight and two buffered");
      resetDut(1'b0);
      for (int i = 1; i <= 3; i++)
         applyStimulus(1'b0, 1'b0, 1'b0, '0);
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0203);
      checkOutput("redir_no_issue", 32'(iccm_rd_en), 32'd0);
      checkRun(32'h0000_0200, 5);

      $display("[TB] address wrap");
      applyStimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8);
      checkOutput("wrap_redir_no_issue", 32'(iccm_rd_en), 32'd0);
      checkRun(32'hFFFF_FFF8, 6);

      $display("[TB] reset mid-operation");
      resetDut(1'b0);
      for (int i = 1; i <= 3; i++)
         applyStimulus(1'b0, 1'b0, 1'b0, '0);
      applyStimulus(1'b1, 1'b0, 1'b0, '0);
      applyStimulus(1'b0, 1'b1, 1'b0, '0);
      checkOutput("mid_rst_rd_en", 32'(iccm_rd_en), 32'd0);
      checkOutput("mid_rst_rd_addr", iccm_rd_addr, RESET_PC);
      checkOutput("mid_rst_valid", 32'(inst_valid), 32'd0);
      checkOutput("mid_rst_inst", inst, 32'd0);
      checkOutput("mid_rst_inst_pc", inst_pc, 32'd0);
      checkRun(RESET_PC, 5);

      $display("[TB] random ready and redirects");
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_1000);
      expPc     = 32'h0000_1000;
      holdValid = 1'b0;
      holdPc    = '0;
      delivered = 0;
      for (int c = 0; c < 3000; c++) begin
         rdy = ($urandom_range(0, 3) != 0);
         rv  = ($urandom_range(0, 40) == 0);
         rpc = $urandom();
         applyStimulus(1'b0, rdy, rv, rpc);
         if (holdValid) begin
            checkOutput("hold_valid", 32'(inst_valid), 32'd1);
            checkOutput("hold_pc", inst_pc, holdPc);
         end
         if (rv)
            checkOutput("rand_redir_no_issue", 32'(iccm_rd_en), 32'd0);
         if (iccm_rd_en)
            checkOutput("rand_addr_align", 32'(iccm_rd_addr[1:0]), 32'd0);
         if (inst_valid && inst_ready && !redirect_valid) begin
            checkOutput("rand_pc", inst_pc, expPc);
            checkOutput("rand_inst", inst, iccmWord(expPc));
            expPc = expPc + 32'd4;
            delivered++;
         end
         holdValid = inst_valid && !inst_ready && !redirect_valid;
         holdPc    = inst_pc;
         if (rv)
            expPc = {rpc[31:2], 2'b00};
      end
      checkOutput("rand_progress", 32'(delivered > 1000), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
